// File: rtl/axi_lite_ar_arbiter.sv
// N-to-1 AXI-lite AR arbiter: round-robin grant, registered output slot, grant-order FIFO for R routing.
// Optional AXI_LITE_AR_ARB_PRIO_EN adds s_arprio; prio-flagged valid masters then win over the rest.
module axi_lite_ar_arbiter #(
  parameter int NUM_MASTERS      = 4,
  parameter int AXI_ARADDR_WIDTH = 8,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int IDX_W            = $clog2(NUM_MASTERS)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_MASTERS-1:0]                  s_arvalid,
  output logic [NUM_MASTERS-1:0]                  s_arready,
  input  logic [NUM_MASTERS*AXI_ARADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS*3-1:0]                s_arprot,
`ifdef AXI_LITE_AR_ARB_PRIO_EN
  input  logic [NUM_MASTERS-1:0]                  s_arprio,
`endif
  output logic                                    m_arvalid,
  input  logic                                    m_arready,
  output logic [AXI_ARADDR_WIDTH-1:0]             m_araddr,
  output logic [2:0]                              m_arprot,
  output logic [IDX_W-1:0]                        rsp_id,
  output logic                                    rsp_id_valid,
  input  logic                                    rsp_pop,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
  output logic                                    err_underflow
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                        mvalid_q;
  logic [AXI_ARADDR_WIDTH-1:0] maddr_q;
  logic [2:0]                  mprot_q;
  logic [IDX_W-1:0]            last_q;
  logic [IDX_W-1:0]            mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]            wptr_q, rptr_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q;

  logic [NUM_MASTERS-1:0] elig;
  logic [IDX_W-1:0]       win, cand;
  logic                   found, slot_free, fifo_ok, accept, pop_ok;

`ifdef AXI_LITE_AR_ARB_PRIO_EN
  assign elig = |(s_arvalid & s_arprio) ? (s_arvalid & s_arprio) : s_arvalid;
`else
  assign elig = s_arvalid;
`endif

  assign slot_free = !mvalid_q || m_arready;
  assign fifo_ok   = (cnt_q < CNT_W'(MAX_OUTSTANDING)) || rsp_pop;
  // Upstream ready is held low while reset is asserted, even though state is already cleared.
  assign accept    = !reset && slot_free && fifo_ok && |elig;
  assign pop_ok    = rsp_pop && (cnt_q != '0);

  always_comb begin
    win   = last_q;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = IDX_W'((int'(last_q) + off) % NUM_MASTERS);
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s_arready = '0;
    if (accept) s_arready[win] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mvalid_q <= 1'b0;
      maddr_q  <= '0;
      mprot_q  <= '0;
      last_q   <= '0;
      mem_q    <= '{default: '0};
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        mvalid_q       <= 1'b1;
        maddr_q        <= s_araddr[win*AXI_ARADDR_WIDTH +: AXI_ARADDR_WIDTH];
        mprot_q        <= s_arprot[win*3 +: 3];
        last_q         <= win;
        mem_q[wptr_q]  <= win;
        wptr_q         <= ptr_inc(wptr_q);
      end else if (slot_free) begin
        mvalid_q <= 1'b0;
      end
      if (pop_ok) rptr_q <= ptr_inc(rptr_q);
      if (rsp_pop && cnt_q == '0) err_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign m_arvalid     = mvalid_q;
  assign m_araddr      = maddr_q;
  assign m_arprot      = mprot_q;
  assign rsp_id_valid  = (cnt_q != '0);
  // Head entry is masked when empty so the index reads 0 after reset.
  assign rsp_id        = rsp_id_valid ? mem_q[rptr_q] : '0;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_axi_lite_ar_arbiter.sv
// Scoreboard bench for axi_lite_ar_arbiter (4 masters, 8-bit addresses, 4 outstanding).
module tb_axi_lite_ar_arbiter;
  logic        clock, reset;
  logic [3:0]  s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [11:0] s_arprot;
`ifdef AXI_LITE_AR_ARB_PRIO_EN
  logic [3:0]  s_arprio;
`endif
  logic        m_arvalid, m_arready;
  logic [7:0]  m_araddr;
  logic [2:0]  m_arprot;
  logic [1:0]  rsp_id;
  logic        rsp_id_valid, rsp_pop;
  logic [2:0]  outstanding;
  logic        err_underflow;

  axi_lite_ar_arbiter #(.NUM_MASTERS(4), .AXI_ARADDR_WIDTH(8), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
`ifdef AXI_LITE_AR_ARB_PRIO_EN
    .s_arprio(s_arprio),
`endif
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .rsp_id(rsp_id), .rsp_id_valid(rsp_id_valid), .rsp_pop(rsp_pop),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] addr;
    logic [2:0] prot;
  } beat_t;

  beat_t      dataq[$];
  logic [1:0] idq[$];
  int         mdl_last;
  bit         mdl_mv, mdl_err;
  int         n_chk, n_fail, n_acc, n_hs;
  logic [3:0] last_rdy;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    dataq.delete();
    idq.delete();
    mdl_last = 0;
    mdl_mv   = 1'b0;
    mdl_err  = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; checks pre-edge state, then advances one clock.
  task automatic cycle();
    logic [3:0] elig, exp_rdy;
    logic [1:0] win;
    bit         slot_free, acc, pop_ok, found;
    int         c;
    #1;
    elig = s_arvalid;
`ifdef AXI_LITE_AR_ARB_PRIO_EN
    if (|(s_arvalid & s_arprio)) elig = s_arvalid & s_arprio;
`endif
    slot_free = !mdl_mv || m_arready;
    acc       = slot_free && (idq.size() < 4 || rsp_pop) && (|elig);
    found     = 1'b0;
    win       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      c = (mdl_last + k) % 4;
      if (!found && elig[c]) begin
        found = 1'b1;
        win   = c[1:0];
      end
    end
    exp_rdy = acc ? (4'b0001 << win) : 4'b0000;
    last_rdy = s_arready;
    chk("s_arready", s_arready, exp_rdy);
    chk("m_arvalid", m_arvalid, mdl_mv);
    chk("outstanding", outstanding, idq.size());
    chk("rsp_id_valid", rsp_id_valid, idq.size() != 0);
    chk("err_underflow", err_underflow, mdl_err);
    if (mdl_mv && dataq.size() != 0) begin
      chk("m_araddr", m_araddr, dataq[0].addr);
      chk("m_arprot", m_arprot, dataq[0].prot);
      if (m_arready) begin
        void'(dataq.pop_front());
        n_hs++;
      end
    end
    if (idq.size() != 0) chk("rsp_id", rsp_id, idq[0]);
    pop_ok = rsp_pop && idq.size() != 0;
    if (rsp_pop && !pop_ok) mdl_err = 1'b1;
    if (pop_ok) void'(idq.pop_front());
    if (acc) begin
      dataq.push_back('{id: win, addr: s_araddr[win*8 +: 8], prot: s_arprot[win*3 +: 3]});
      idq.push_back(win);
      mdl_last = win;
      n_acc++;
      mdl_mv = 1'b1;
    end else if (slot_free) begin
      mdl_mv = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] v, input logic rdy, input logic pop);
    s_arvalid = v;
    m_arready = rdy;
    rsp_pop   = pop;
    s_araddr  = $urandom;
    s_arprot  = 12'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (idq.size() != 0 || mdl_mv); i++) begin
      drive(4'b0000, 1'b1, idq.size() != 0);
      cycle();
    end
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    int a0, h0;
    n_chk = 0; n_fail = 0; n_acc = 0; n_hs = 0;
    mdl_reset();
`ifdef AXI_LITE_AR_ARB_PRIO_EN
    s_arprio = 4'b0000;
`endif
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    #12;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_id_valid", rsp_id_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_err", err_underflow, 0);
    @(negedge clock);
    reset = 1'b0;

    // Prime the pointer on master 3 so full rotation starts at master 0.
    drive(4'b1000, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 12; i++) begin
      drive(4'b1111, 1'b1, idq.size() != 0);
      cycle();
      chk("rr_grant", last_rdy, 4'b0001 << (i % 4));
    end
    drain();

    // Backpressure: one beat held for 5 cycles, then exactly one transfer.
    drive(4'b0010, 1'b0, 1'b0);
    s_araddr[15:8] = 8'h3C;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_m_arvalid", m_arvalid, 1);
      chk("bp_m_araddr", m_araddr, 8'h3C);
      chk("bp_s_arready", s_arready, 0);
    end
    h0 = n_hs;
    drive(4'b0000, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("bp_one_beat", n_hs - h0, 1);
    drain();

    // Outstanding limit with a lone requester.
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, 1'b1, 1'b0);
      cycle();
    end
    chk("lim_accepts", n_acc - a0, 4);
    chk("lim_outstanding", outstanding, 4);
    drive(4'b0001, 1'b1, 1'b1);
    cycle();
    chk("lim_pop_accept", n_acc - a0, 5);
    chk("lim_pop_outstanding", outstanding, 4);
    drive(4'b0001, 1'b1, 1'b0);
    cycle();
    chk("lim_stall", n_acc - a0, 5);
    drain();

    // Underflow is sticky.
    drive(4'b0000, 1'b1, 1'b1);
    cycle();
    chk("uf_err", err_underflow, 1);
    chk("uf_outstanding", outstanding, 0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, 1'b0);
      cycle();
    end
    chk("uf_err_held", err_underflow, 1);

    // Asynchronous reset in the middle of a cycle with a beat in flight.
    drive(4'b0101, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_valid", m_arvalid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_m_arvalid", m_arvalid, 0);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_err", err_underflow, 0);
    chk("arst_rsp_id_valid", rsp_id_valid, 0);
    chk("arst_s_arready", s_arready, 0);
    chk("arst_m_araddr", m_araddr, 0);
    mdl_reset();
    @(negedge clock);
    reset = 1'b0;

`ifdef AXI_LITE_AR_ARB_PRIO_EN
    drive(4'b1000, 1'b1, 1'b0);
    cycle();
    s_arprio = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 1'b1, idq.size() != 0);
      cycle();
      chk("prio_grant", last_rdy, 4'b1000);
    end
    s_arprio = 4'b0000;
    drive(4'b1111, 1'b1, idq.size() != 0);
    cycle();
    chk("prio_resume", last_rdy, 4'b0001);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
`ifdef AXI_LITE_AR_ARB_PRIO_EN
      s_arprio = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_ar_arbiter.md
Name: axi_lite_ar_arbiter

Overview:
- N-to-1 AXI-lite read address channel arbiter with a registered output stage and a grant-order FIFO.
- Accepts AR beats from NUM_MASTERS upstream masters and forwards one at a time to a single downstream slave AR channel.
- Records the granted master index in issue order, so the R-channel router can return read data to the correct master.
- Sits between the processor-side AXI-lite masters and the shared register-file slave port.

Parameters:
- NUM_MASTERS, 4: number of upstream AR channels; legal range 2..16.
- AXI_ARADDR_WIDTH, 8: address width on all AR channels.
- MAX_OUTSTANDING, 4: depth of the grant-order FIFO, i.e. the maximum number of accepted AR beats not yet retired by rsp_pop; legal range 1..16.
- IDX_W, $clog2(NUM_MASTERS): width of a master index (derived, do not override).

Ports:
- clock  input  1  single clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_arvalid  input  NUM_MASTERS  per-master AR valid.
- s_arready  output  NUM_MASTERS  per-master AR ready; one-hot or zero.
- s_araddr  input  NUM_MASTERS*AXI_ARADDR_WIDTH  packed addresses; master i occupies slice i.
- s_arprot  input  NUM_MASTERS*3  packed protection bits; master i occupies slice i.
- m_arvalid  output  1  downstream AR valid (registered).
- m_arready  input  1  downstream AR ready.
- m_araddr  output  AXI_ARADDR_WIDTH  downstream address (registered).
- m_arprot  output  3  downstream protection (registered).
- rsp_id  output  IDX_W  master index at the head of the grant-order FIFO.
- rsp_id_valid  output  1  FIFO not empty.
- rsp_pop  input  1  R handshake completed downstream; retire the FIFO head.
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_underflow  output  1  sticky: rsp_pop was seen while the FIFO was empty.

Behaviour:
- Reset: asserting reset clears everything immediately, without waiting for a clock edge:
  - m_arvalid, m_araddr, m_arprot, rsp_id_valid, rsp_id, outstanding and err_underflow all go to 0;
  - the round-robin pointer goes to 0 and the FIFO pointers go to 0.
  - A reset mid-transaction drops the in-flight beat and all FIFO entries; upstream ready is forced low while reset is high.
- Output stage: a single register, either EMPTY or FULL.
  - slot_free = !m_arvalid || m_arready.
  - fifo_ok = (outstanding < MAX_OUTSTANDING) || rsp_pop. A pop and a push in the same cycle at full are allowed.
  - An accept happens this cycle iff slot_free && fifo_ok && |s_arvalid.
- Arbitration: round-robin.
  - Search starts at index (last_grant+1) mod NUM_MASTERS, with wrap-around; the first valid master wins.
  - s_arready[win] = 1 combinationally in the accept cycle only; all other s_arready bits are 0.
  - s_arready may depend on s_arvalid; no master's valid depends on its ready.
- On accept (rising edge):
  - m_arvalid <= 1; m_araddr and m_arprot load from the winner's slice.
  - last_grant <= win; win is pushed into the FIFO.
- If slot_free and there is no accept, m_arvalid <= 0.
- While m_arvalid && !m_arready, m_araddr and m_arprot are held stable (AXI rule).
- Timing: latency is 1 cycle from upstream handshake to m_arvalid. Throughput is 1 beat per cycle when m_arready is held high.
- FIFO: rsp_id and rsp_id_valid are driven from registered state, not from a combinational bypass. An index pushed at edge k is visible at the head no earlier than after edge k.
- Occupancy arithmetic (saturating never needed):
  - push only: outstanding + 1;
  - pop only: outstanding − 1;
  - push and pop together: unchanged.
- Pop on empty: ignored (pointers and count unchanged); err_underflow <= 1 and stays set until reset.
- Single valid master: it is granted every cycle the slot is free. The pointer does not starve it.

Optional Feature:
- Macro AXI_LITE_AR_ARB_PRIO_EN.
- When defined:
  - An extra input port s_arprio [NUM_MASTERS-1:0] is added.
  - If any valid master has its prio bit set, only prio masters compete; round-robin applies among them from the same shared last_grant pointer.
  - Otherwise arbitration is normal.
- When undefined: the port does not exist and arbitration is pure round-robin. Gate count and behaviour are identical to a build without the feature.

Test Plan:
- Reset during traffic: masters 0 and 2 valid, reset asserted mid-cycle with m_arvalid=1 → m_arvalid and outstanding read 0 before the next clock edge; err_underflow=0.
- All 4 masters valid continuously, m_arready=1, rsp_pop every cycle → grants 0,1,2,3,0,… one per cycle; rsp_id sequence matches; m_araddr equals the granting master's address one cycle after each grant.
- Backpressure: m_arready=0 for 5 cycles with master 1 valid, address 0x3C → m_arvalid=1 and m_araddr=0x3C held stable; s_arready=0 throughout; after m_arready=1, exactly one beat is transferred.
- Outstanding limit: MAX_OUTSTANDING=4, no rsp_pop, master 0 always valid → exactly 4 accepts, outstanding=4, then s_arready stays 0. A single rsp_pop with a simultaneous request → a 5th accept occurs and outstanding remains 4.
- Underflow: rsp_pop=1 with the FIFO empty → outstanding stays 0 and err_underflow=1, held until reset.
- With AXI_LITE_AR_ARB_PRIO_EN defined: masters 0–3 valid, s_arprio=4'b1000 → master 3 is granted every cycle; with prio cleared, rotation resumes at master 0.
